// File: rtl/spi_slave_if.sv
// Host-side and pin-side signals of the SPI responder, grouped for port hookup.
// The slave modport is the responder's view; master is the driving environment.
interface spi_slave_if;
  logic [7:0] i_Tx_Byte;
  logic       i_Tx_Valid;
  logic       o_Tx_Ready;
  logic       o_Tx_Underrun;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Ready;
  logic       i_SPI_Clk;
  logic       i_SPI_CSLow;
  logic       i_SPI_Mosi;
  logic       o_SPI_Miso;
  logic       o_SPI_MisoEn;

  modport slave (
    input  i_Tx_Byte, i_Tx_Valid, i_SPI_Clk, i_SPI_CSLow, i_SPI_Mosi,
    output o_Tx_Ready, o_Tx_Underrun, o_Rx_Byte, o_Rx_Ready, o_SPI_Miso, o_SPI_MisoEn
  );

  modport master (
    output i_Tx_Byte, i_Tx_Valid, i_SPI_Clk, i_SPI_CSLow, i_SPI_Mosi,
    input  o_Tx_Ready, o_Tx_Underrun, o_Rx_Byte, o_Rx_Ready, o_SPI_Miso, o_SPI_MisoEn
  );
endinterface

// File: rtl/spi_slave.sv
// SPI responder, all four CPOL/CPHA modes, MSB first, 8-bit frames, oversampled in clk domain.
// Pin events act 3 clk cycles after they occur; one-byte transmit holding register.
module spi_slave #(
  parameter bit         CPOL       = 1'b0,
  parameter bit         CPHA       = 1'b0,
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  spi_slave_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state;
  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       cs_s1, cs_s2, cs_s3;
  logic       mosi_s1, mosi_s2;
  logic [7:0] hold_byte;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] rx_byte;
  logic [2:0] bit_cnt;
  logic       tx_ready;
  logic       tx_underrun;
  logic       rx_ready;
  logic       miso;
  logic       miso_en;
  logic       skip_shift;

  logic       lead_evt, trail_evt, sample_evt, shift_evt;
  logic       cs_fall, cs_rise, load;
  logic [7:0] next_tx;
  logic [7:0] rx_next;

  always_comb begin
    lead_evt   = (sclk_s2 != CPOL) && (sclk_s3 == CPOL);
    trail_evt  = (sclk_s2 == CPOL) && (sclk_s3 != CPOL);
    sample_evt = CPHA ? trail_evt : lead_evt;
    shift_evt  = CPHA ? lead_evt : trail_evt;
    cs_fall    = !cs_s2 && cs_s3;
    cs_rise    = cs_s2 && !cs_s3;
    next_tx    = tx_ready ? DEFAULT_TX : hold_byte;
    rx_next    = {rx_shift[6:0], mosi_s2};
    load       = ((state == IDLE) && cs_fall) ||
                 ((state == ACTIVE) && !cs_rise && sample_evt && (bit_cnt == 3'd7));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      sclk_s1     <= CPOL;
      sclk_s2     <= CPOL;
      sclk_s3     <= CPOL;
      cs_s1       <= 1'b1;
      cs_s2       <= 1'b1;
      cs_s3       <= 1'b1;
      mosi_s1     <= 1'b0;
      mosi_s2     <= 1'b0;
      hold_byte   <= 8'h00;
      tx_shift    <= 8'h00;
      rx_shift    <= 8'h00;
      rx_byte     <= 8'h00;
      bit_cnt     <= 3'd0;
      tx_ready    <= 1'b1;
      tx_underrun <= 1'b0;
      rx_ready    <= 1'b0;
      miso        <= 1'b0;
      miso_en     <= 1'b0;
      skip_shift  <= 1'b0;
    end else begin
      sclk_s1     <= bus.i_SPI_Clk;
      sclk_s2     <= sclk_s1;
      sclk_s3     <= sclk_s2;
      cs_s1       <= bus.i_SPI_CSLow;
      cs_s2       <= cs_s1;
      cs_s3       <= cs_s2;
      mosi_s1     <= bus.i_SPI_Mosi;
      mosi_s2     <= mosi_s1;
      tx_underrun <= 1'b0;
      rx_ready    <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= ACTIVE;
            miso_en <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state      <= IDLE;
            miso_en    <= 1'b0;
            bit_cnt    <= 3'd0;
            rx_shift   <= 8'h00;
            tx_shift   <= 8'h00;
            miso       <= 1'b0;
            skip_shift <= 1'b0;
          end else begin
            if (sample_evt) begin
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_byte  <= rx_next;
                rx_ready <= 1'b1;
              end
            end
            // A back-to-back reload in CPHA=0 already presented bit7, so the next trailing edge must not shift
            if (shift_evt) begin
              if (!CPHA && skip_shift) begin
                skip_shift <= 1'b0;
              end else begin
                miso     <= tx_shift[7];
                tx_shift <= {tx_shift[6:0], 1'b0};
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        tx_underrun <= tx_ready;
        tx_ready    <= 1'b1;
        bit_cnt     <= 3'd0;
        if (CPHA) begin
          tx_shift <= next_tx;
        end else begin
          miso       <= next_tx[7];
          tx_shift   <= {next_tx[6:0], 1'b0};
          skip_shift <= (state == ACTIVE);
        end
      end

      // Placed after the load so a byte offered while empty is kept for the following frame
      if (bus.i_Tx_Valid && tx_ready) begin
        hold_byte <= bus.i_Tx_Byte;
        tx_ready  <= 1'b0;
      end
    end
  end

  assign bus.o_Tx_Ready    = tx_ready;
  assign bus.o_Tx_Underrun = tx_underrun;
  assign bus.o_Rx_Byte     = rx_byte;
  assign bus.o_Rx_Ready    = rx_ready;
  assign bus.o_SPI_Miso    = miso;
  assign bus.o_SPI_MisoEn  = miso_en;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one responder per SPI mode, driven by a behavioural master at SCLK = clk/10.
module tb_spi_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [3:0]      sclk, cs_n, mosi, tx_valid;
  logic [3:0]      tx_rdy, tx_und, rx_rdy, miso, miso_en;
  logic [3:0][7:0] tx_byte, rx_byte;

  int          n_cmp = 0;
  int          n_err = 0;
  int          rx_cnt [4];
  int          und_start [4];
  logic [15:0] rx_seq [4];
  logic        rdy_at2, rdy_at3;
  logic [15:0] got;
  int          base_rx, base_und;

  logic [7:0] mst_t [3] = '{8'h3C, 8'hF0, 8'hFF};
  logic [7:0] slv_t [3] = '{8'hC3, 8'h0F, 8'h81};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_if sif ();
    assign sif.i_Tx_Byte   = tx_byte[g];
    assign sif.i_Tx_Valid  = tx_valid[g];
    assign sif.i_SPI_Clk   = sclk[g];
    assign sif.i_SPI_CSLow = cs_n[g];
    assign sif.i_SPI_Mosi  = mosi[g];
    assign tx_rdy[g]       = sif.o_Tx_Ready;
    assign tx_und[g]       = sif.o_Tx_Underrun;
    assign rx_byte[g]      = sif.o_Rx_Byte;
    assign rx_rdy[g]       = sif.o_Rx_Ready;
    assign miso[g]         = sif.o_SPI_Miso;
    assign miso_en[g]      = sif.o_SPI_MisoEn;

    spi_slave #(
      .CPOL       (g >= 2),
      .CPHA       ((g % 2) == 1),
      .DEFAULT_TX (8'hFF)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif.slave)
    );
  end

  // Pulse monitor; an underrun not coincident with o_Rx_Ready comes from a CS-fall load
  always @(negedge clk) begin
    if (reset) begin
      for (int g = 0; g < 4; g++) begin
        if (rx_rdy[g]) begin
          rx_cnt[g]++;
          rx_seq[g] = {rx_seq[g][7:0], rx_byte[g]};
        end
        if (tx_und[g] && !rx_rdy[g]) und_start[g]++;
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input int m, input logic [7:0] b);
    int n = 0;
    while (!tx_rdy[m] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_wait", 16'(n >= 200), 16'd0);
    tx_byte[m]  = b;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
  endtask

  task automatic xfer(input int m, input logic [15:0] mo, input int nbits, input bit raise);
    bit cpol = (m >= 2);
    bit cpha = ((m % 2) == 1);
    got = 16'h0;
    @(negedge clk);
    cs_n[m] = 1'b0;
    if (!cpha) mosi[m] = mo[nbits-1];
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 2) rdy_at2 = tx_rdy[m];
      if (c == 3) rdy_at3 = tx_rdy[m];
    end
    chk($sformatf("m%0d_misoen", m), 16'(miso_en[m]), 16'd1);
    for (int i = 0; i < nbits; i++) begin
      if (cpha) mosi[m] = mo[nbits-1-i];
      else      got = {got[14:0], miso[m]};
      sclk[m] = ~cpol;
      repeat (5) @(negedge clk);
      if (cpha) got = {got[14:0], miso[m]};
      sclk[m] = cpol;
      if (!cpha && i < nbits - 1) mosi[m] = mo[nbits-2-i];
      repeat (5) @(negedge clk);
    end
    if (raise) cs_n[m] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b0;
    sclk     = 4'b1100;
    cs_n     = 4'hF;
    mosi     = 4'h0;
    tx_valid = 4'h0;
    tx_byte  = '0;
    repeat (3) @(negedge clk);
    chk("rst_txrdy",  16'(tx_rdy),  16'h000F);
    chk("rst_und",    16'(tx_und),  16'h0000);
    chk("rst_rxbyte", 16'(rx_byte[0] | rx_byte[3]), 16'h0000);
    chk("rst_rxrdy",  16'(rx_rdy),  16'h0000);
    chk("rst_miso",   16'(miso),    16'h0000);
    chk("rst_misoen", 16'(miso_en), 16'h0000);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Mode 0 with preloaded byte
    push(0, 8'h3C);
    chk("t1_rdy_after_push", 16'(tx_rdy[0]), 16'd0);
    base_rx = rx_cnt[0]; base_und = und_start[0];
    xfer(0, 16'h00A5, 8, 1'b1);
    chk("t1_rx",      16'(rx_byte[0]), 16'h00A5);
    chk("t1_miso",    got,             16'h003C);
    chk("t1_rxcnt",   16'(rx_cnt[0] - base_rx),     16'd1);
    chk("t1_und",     16'(und_start[0] - base_und), 16'd0);
    chk("t1_rdy_cs2", 16'(rdy_at2), 16'd0);
    chk("t1_rdy_cs3", 16'(rdy_at3), 16'd1);

    // Modes 1..3
    for (int k = 0; k < 3; k++) begin
      push(k + 1, slv_t[k]);
      base_rx = rx_cnt[k+1];
      xfer(k + 1, {8'h00, mst_t[k]}, 8, 1'b1);
      chk($sformatf("t2_m%0d_rx", k + 1),    16'(rx_byte[k+1]), {8'h00, mst_t[k]});
      chk($sformatf("t2_m%0d_miso", k + 1),  got,               {8'h00, slv_t[k]});
      chk($sformatf("t2_m%0d_rxcnt", k + 1), 16'(rx_cnt[k+1] - base_rx), 16'd1);
    end

    // Empty holding register
    base_und = und_start[0];
    xfer(0, 16'h0055, 8, 1'b1);
    chk("t3_miso", got, 16'h00FF);
    chk("t3_und",  16'(und_start[0] - base_und), 16'd1);
    chk("t3_rx",   16'(rx_byte[0]), 16'h0055);

    // Two bytes under one CS
    push(0, 8'hAB);
    base_rx = rx_cnt[0];
    fork
      xfer(0, 16'h1234, 16, 1'b1);
      begin
        repeat (20) @(negedge clk);
        push(0, 8'hCD);
      end
    join
    chk("t4_miso",  got, 16'hABCD);
    chk("t4_rxcnt", 16'(rx_cnt[0] - base_rx), 16'd2);
    chk("t4_rxseq", rx_seq[0], 16'h1234);

    // Aborted frame, holding byte loaded during it survives
    base_rx = rx_cnt[0];
    fork
      xfer(0, 16'h0007, 3, 1'b1);
      begin
        repeat (12) @(negedge clk);
        push(0, 8'h69);
      end
    join
    chk("t5_abort_rxcnt", 16'(rx_cnt[0] - base_rx), 16'd0);
    chk("t5_hold_kept",   16'(tx_rdy[0]), 16'd0);
    xfer(0, 16'h0096, 8, 1'b1);
    chk("t5_rx",    16'(rx_byte[0]), 16'h0096);
    chk("t5_miso",  got, 16'h0069);
    chk("t5_rxcnt", 16'(rx_cnt[0] - base_rx), 16'd1);

    // Reset in the middle of a frame
    base_rx = rx_cnt[0];
    fork
      xfer(0, 16'h00C3, 8, 1'b1);
      begin
        repeat (30) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_txrdy",  16'(tx_rdy[0]),  16'd1);
        chk("t6_und",    16'(tx_und[0]),  16'd0);
        chk("t6_rxbyte", 16'(rx_byte[0]), 16'h0000);
        chk("t6_rxrdy",  16'(rx_rdy[0]),  16'd0);
        chk("t6_miso",   16'(miso[0]),    16'd0);
        chk("t6_misoen", 16'(miso_en[0]), 16'd0);
        reset = 1'b1;
      end
    join
    chk("t6_abort_rxcnt", 16'(rx_cnt[0] - base_rx), 16'd0);
    xfer(0, 16'h005A, 8, 1'b1);
    chk("t6_rx",    16'(rx_byte[0]), 16'h005A);
    chk("t6_rxcnt", 16'(rx_cnt[0] - base_rx), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
